baud_gen_frac: RTL

Parametrised, runtime-programmable successor to the fixed 115200-baud generator. A single fractional divider produces the RX oversample tick (rx_en). tx_en is derived by counting OVERSAMPLE of those ticks, so TX and RX never drift apart. Adds divisor reload at tick boundaries, an enable input, RX phase resync on start-bit detection, and a mid-bit sample strobe. Sits between the system clock and the uart_tx/uart_rx FSMs.

---
 rtl/baud_gen_frac.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator. One fractional divider produces the RX
// oversample tick; the TX bit tick is every OVERSAMPLE-th RX tick, so the
// two never drift apart. Supports divisor reload on tick boundaries, an
// enable, RX phase resync and a mid-bit sample strobe.
module baud_gen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_DIV  = 27,
    parameter int DEFAULT_FRAC = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [DIV_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          div_load,
    input  logic                          rx_sync,
    output logic                          tx_en,
    output logic                          rx_en,
    output logic                          rx_mid,
    output logic [$clog2(OVERSAMPLE)-1:0] rx_phase,
    output logic                          div_err
);

    localparam int                PH_W     = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0]  MIN_DIV  = DIV_W'(2);
    localparam logic [DIV_W-1:0]  RST_DIV  = (DEFAULT_DIV < 2) ? MIN_DIV : DIV_W'(DEFAULT_DIV);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEFAULT_FRAC);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0]   PH_MID   = PH_W'(OVERSAMPLE / 2);

    // Active and pending divisor configuration
    logic [DIV_W-1:0]  div_act;
    logic [FRAC_W-1:0] frac_act;
    logic [DIV_W-1:0]  pend_int;
    logic [FRAC_W-1:0] pend_frac;
    logic              pending;

    // Base divider state
    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic              carry;
    logic [PH_W-1:0]   tcnt;

    // Derived combinational terms
    logic [DIV_W:0]    period_m1;
    logic              wrap;
    logic              apply;
    logic              clamped;
    logic [DIV_W-1:0]  div_new;
    logic [FRAC_W:0]   acc_sum;
    logic [PH_W-1:0]   phase_inc;

    // Current period is div_act plus the carry earned at the previous wrap;
    // div_act is never below 2, so the subtraction cannot underflow.
    assign period_m1 = {1'b0, div_act} + {{DIV_W{1'b0}}, carry} - {{DIV_W{1'b0}}, 1'b1};
    assign wrap      = en && ({1'b0, cnt} == period_m1);
    assign apply     = pending && (wrap || !en);
    assign clamped   = pend_int < MIN_DIV;
    assign div_new   = clamped ? MIN_DIV : pend_int;
    assign acc_sum   = {1'b0, acc} + {1'b0, frac_act};
    assign phase_inc = rx_phase + PH_W'(1);

    // Divisor configuration: capture loads, promote them at a wrap (or at once when disabled)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_act   <= RST_DIV;
            frac_act  <= RST_FRAC;
            pend_int  <= '0;
            pend_frac <= '0;
            pending   <= 1'b0;
            div_err   <= 1'b0;
        end else begin
            if (apply) begin
                div_act  <= div_new;
                frac_act <= pend_frac;
                div_err  <= clamped;
            end
            if (div_load) begin
                pend_int  <= div_int;
                pend_frac <= div_frac;
                pending   <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    // Base counter with fractional accumulator; a fresh divisor starts with a clean accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= '0;
            carry <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            acc   <= '0;
            carry <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            if (apply) begin
                acc   <= '0;
                carry <= 1'b0;
            end else begin
                acc   <= acc_sum[FRAC_W-1:0];
                carry <= acc_sum[FRAC_W];
            end
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    // Registered tick pulses, TX tick counter and RX phase tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt     <= '0;
            tx_en    <= 1'b0;
            rx_en    <= 1'b0;
            rx_mid   <= 1'b0;
            rx_phase <= '0;
        end else if (!en) begin
            tcnt     <= '0;
            tx_en    <= 1'b0;
            rx_en    <= 1'b0;
            rx_mid   <= 1'b0;
            rx_phase <= '0;
        end else begin
            rx_en <= wrap;
            tx_en <= wrap && (tcnt == PH_LAST);
            if (wrap) begin
                tcnt <= tcnt + PH_W'(1);
            end
            if (rx_sync) begin
                rx_phase <= '0;
                rx_mid   <= 1'b0;
            end else if (wrap) begin
                rx_phase <= phase_inc;
                rx_mid   <= (phase_inc == PH_MID);
            end else begin
                rx_mid <= 1'b0;
            end
        end
    end

endmodule
